// File: rtl/multibyte_add_seq.sv
// Byte-serial multi-byte adder/subtractor sequencer driving an external 8-bit adder.
// One byte per RUN cycle, LSB first; flags are registered on the final byte.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  OP_SUB,
  input  logic [8*NBYTES-1:0]   A,
  input  logic [8*NBYTES-1:0]   B,
  input  logic                  C_IN,
  output logic [7:0]            ADD_A,
  output logic [7:0]            ADD_B,
  output logic                  ADD_C_IN,
  input  logic [7:0]            ADD_Y,
  input  logic                  ADD_C_OUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [8*NBYTES-1:0]   Y,
  output logic                  C_OUT,
  output logic                  Z,
  output logic                  V,
  output logic                  BUSY
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    opa_q, opa_d;
  logic [W-1:0]    opb_q, opb_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    y_q, y_d;
  logic            cout_q, cout_d;
  logic            z_q, z_d;
  logic            v_q, v_d;
  logic [IW+2:0]   bofs;

  assign bofs = {idx_q, 3'b000};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      z_q     <= 1'b1;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      z_q     <= z_d;
      v_q     <= v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    y_d      = y_q;
    cout_d   = cout_q;
    z_d      = z_q;
    v_d      = v_q;
    ADD_A    = '0;
    ADD_B    = '0;
    ADD_C_IN = 1'b0;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          state_d = RUN;
          opa_d   = A;
          // Subtraction is A + ~B + ~borrow, so only B and the carry change.
          opb_d   = OP_SUB ? ~B : B;
          carry_d = C_IN ^ OP_SUB;
          idx_d   = '0;
        end
      end
      RUN: begin
        ADD_A           = opa_q[bofs +: 8];
        ADD_B           = opb_q[bofs +: 8];
        ADD_C_IN        = carry_q;
        y_d[bofs +: 8]  = ADD_Y;
        carry_d         = ADD_C_OUT;
        if (idx_q == LAST) begin
          state_d = DONE;
          cout_d  = ADD_C_OUT;
          v_d     = (opa_q[W-1] == opb_q[W-1]) && (ADD_Y[7] != opa_q[W-1]);
          z_d     = (y_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (OUT_READY) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == DONE);
  assign BUSY      = (state_q != IDLE);
  assign Y         = y_q;
  assign C_OUT     = cout_q;
  assign Z         = z_q;
  assign V         = v_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Scoreboard bench for multibyte_add_seq with a behavioural 8-bit adder attached.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          CLK = 1'b0;
  logic          RST, IN_VALID, IN_READY, OP_SUB, C_IN;
  logic [W-1:0]  A, B, Y;
  logic [7:0]    ADD_A, ADD_B, ADD_Y;
  logic          ADD_C_IN, ADD_C_OUT;
  logic          OUT_VALID, OUT_READY, C_OUT, Z, V, BUSY;

  typedef struct packed {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  assign {ADD_C_OUT, ADD_Y} = {1'b0, ADD_A} + {1'b0, ADD_B} + {8'd0, ADD_C_IN};

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP_SUB(OP_SUB), .A(A), .B(B), .C_IN(C_IN),
    .ADD_A(ADD_A), .ADD_B(ADD_B), .ADD_C_IN(ADD_C_IN),
    .ADD_Y(ADD_Y), .ADD_C_OUT(ADD_C_OUT),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Y(Y), .C_OUT(C_OUT), .Z(Z), .V(V), .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    logic [W:0] r;
    exp_t e;
    if (!sub) begin
      r   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      e.c = r[W];
      e.v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r   = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      e.c = ~r[W];
      e.v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    e.y = r[W-1:0];
    e.z = (r[W-1:0] == '0);
    return e;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, input int hold, input logic early_rdy);
    int cnt;
    exp_t e;
    logic [W-1:0] ysnap;
    cnt = 0;
    while (!IN_READY && cnt < 20) begin tick(); cnt++; end
    check("in_ready_wait", IN_READY, 1);
    A = a; B = b; C_IN = cin; OP_SUB = sub; IN_VALID = 1'b1;
    OUT_READY = early_rdy;
    sb.push_back(model(a, b, cin, sub));
    tick();
    IN_VALID = 1'b0;
    cnt = 0;
    while (!OUT_VALID && cnt < 20) begin
      if (cnt < NB) check("add_a_byte", ADD_A, a[8*cnt +: 8]);
      check("busy_run", BUSY, 1);
      cnt++;
      tick();
    end
    check("latency", cnt, NB);
    check("add_a_done", ADD_A, 0);
    if (hold > 0) begin
      ysnap = Y;
      A = ~a; B = ~b; IN_VALID = 1'b1;
      repeat (hold) begin
        check("hold_in_ready", IN_READY, 0);
        check("hold_valid", OUT_VALID, 1);
        tick();
        check("hold_y_stable", Y, ysnap);
      end
      IN_VALID = 1'b0;
    end
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("y", Y, e.y);
      check("c_out", C_OUT, e.c);
      check("z", Z, e.z);
      check("v", V, e.v);
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("post_valid", OUT_VALID, 0);
    check("post_in_ready", IN_READY, 1);
    check("post_y_kept", Y, e.y);
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 1'b1; OP_SUB = 1'b0; C_IN = 1'b0;
    A = 32'h1234_5678; B = 32'h1; OUT_READY = 1'b0;
    tick();
    tick();
    check("rst_busy", BUSY, 0);
    check("rst_valid", OUT_VALID, 0);
    check("rst_in_ready", IN_READY, 1);
    check("rst_y", Y, 0);
    check("rst_c", C_OUT, 0);
    check("rst_z", Z, 1);
    check("rst_v", V, 0);
    RST = 1'b0; IN_VALID = 1'b0;

    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 0, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0);
    do_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 3, 1'b0);
    do_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 6; i++)
      do_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            0, 1'($urandom_range(0, 1)));

    // Reset in the middle of an operation.
    A = 32'hA1B2_C3D4; B = 32'h1111_1111; C_IN = 1'b0; OP_SUB = 1'b0; IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    tick();
    tick();
    check("mid_add_a_byte2", ADD_A, 8'hB2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_valid", OUT_VALID, 0);
    check("mid_rst_y", Y, 0);
    check("mid_rst_add_a", ADD_A, 0);
    check("mid_rst_add_b", ADD_B, 0);
    check("mid_rst_z", Z, 1);
    do_op(32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 0, 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1);
  end

endmodule

// File: doc/multibyte_add_seq.md
MULTIBYTE_ADD_SEQ -- requirements
Module: multibyte_add_seq

Interface
REQ-001 Parameter: NBYTES, default 4, is the operand width in bytes; NBYTES SHALL be at least 2.
REQ-002 CLK  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 RST  in  1  is the reset, which SHALL be synchronous and active-high.
REQ-004 IN_VALID  in  1  SHALL signal that the requester presents an operation.
REQ-005 IN_READY  out  1  SHALL signal that the sequencer accepts an operation this cycle.
REQ-006 OP_SUB  in  1  SHALL select the operation: 0 = A+B+C_IN, 1 = A-B-borrow.
REQ-007 A, B  in  8*NBYTES  SHALL carry the operands.
REQ-008 C_IN  in  1  SHALL carry the carry-in when adding and the borrow-in when subtracting.
REQ-009 ADD_A, ADD_B  out  8  SHALL drive the byte operands to the external 8-bit adder.
REQ-010 ADD_C_IN  out  1  SHALL drive the carry into the external adder.
REQ-011 ADD_Y  in  8  SHALL carry the external adder sum, combinational from ADD_A/ADD_B/ADD_C_IN.
REQ-012 ADD_C_OUT  in  1  SHALL carry the external adder carry-out.
REQ-013 OUT_VALID  out  1  SHALL signal that a result is held.
REQ-014 OUT_READY  in  1  SHALL signal that the consumer takes the result.
REQ-015 Y  out  8*NBYTES  SHALL carry the result.
REQ-016 C_OUT  out  1  SHALL carry the raw final carry; when subtracting, 1 = no borrow.
REQ-017 Z  out  1  SHALL be asserted when Y==0.
REQ-018 V  out  1  SHALL flag signed two's-complement overflow.
REQ-019 BUSY  out  1  SHALL be asserted whenever the state is not IDLE.

Function
REQ-020 The FSM SHALL have three states, IDLE, RUN and DONE, with these transitions: IDLE->RUN on IN_VALID&IN_READY; RUN->DONE when byte index==NBYTES-1; DONE->IDLE on OUT_READY; otherwise hold.
REQ-021 IN_READY SHALL equal 1 only in IDLE; IN_VALID in RUN or DONE SHALL be ignored, with no queuing.
REQ-022 On acceptance the block SHALL register the following: opA=A; opB=B when OP_SUB=0, else opB=~B; carry=C_IN^OP_SUB; sub flag; byte index=0.
REQ-023 In RUN the outputs SHALL be driven as ADD_A=opA[8i+7:8i], ADD_B=opB[8i+7:8i] and ADD_C_IN=carry, all from registered state only.
REQ-024 At each RUN edge the block SHALL update Y[8i+7:8i]<=ADD_Y, carry<=ADD_C_OUT and i<=i+1.
REQ-025 On the final RUN edge (i==NBYTES-1), the block SHALL register the following: C_OUT<=ADD_C_OUT; V<=(opA msb==opB msb)&(ADD_Y[7]!=opA msb), where opB is the possibly inverted value; Z<=(full next Y==0).
REQ-026 In IDLE and DONE, ADD_A, ADD_B and ADD_C_IN SHALL be 0.
REQ-027 Latency: an operation accepted at edge k SHALL be in RUN for cycles k+1..k+NBYTES, and OUT_VALID SHALL be 1 from cycle k+NBYTES+1.
REQ-028 While OUT_VALID=1 and OUT_READY=0, Y, C_OUT, Z and V SHALL hold stable.
REQ-029 If OUT_READY=1 on the first DONE cycle, the transfer SHALL occur at that edge and IN_READY SHALL be 1 on the next cycle; the minimum issue interval SHALL be NBYTES+2 cycles.
REQ-030 In IDLE, Y, C_OUT, Z and V SHALL retain the last result.
REQ-031 The byte index SHALL never exceed NBYTES-1; its wrap back to 0 SHALL occur only on the next acceptance.
REQ-032 OUT_READY outside DONE SHALL have no effect.

Reset
REQ-033 RST=1 at an edge SHALL force the following: state=IDLE; OUT_VALID=0; BUSY=0; IN_READY=1 on the next cycle; Y=0; C_OUT=0; Z=1; V=0; carry=0; index=0.
REQ-034 RST SHALL take priority over every other input.
REQ-035 RST asserted during RUN or DONE SHALL discard the in-flight operation with no OUT_VALID pulse.
REQ-036 RST and IN_VALID in the same cycle SHALL result in no acceptance.

Verification
REQ-037 Add, NBYTES=4: A=0x000000FF, B=0x00000001, C_IN=0 -> Y=0x00000100, C_OUT=0, Z=0, V=0, with OUT_VALID at cycle k+5.
REQ-038 Wrap: A=0xFFFFFFFF, B=0x00000001, C_IN=0 -> Y=0x00000000, C_OUT=1, Z=1, V=0.
REQ-039 Sub: OP_SUB=1, A=0x00000005, B=0x00000007, C_IN=0 -> Y=0xFFFFFFFE, C_OUT=0 (borrow), V=0; with C_IN=1 -> Y=0xFFFFFFFD.
REQ-040 Overflow: A=0x7FFFFFFF, B=0x00000001 -> Y=0x80000000, V=1, C_OUT=0.
REQ-041 Backpressure: hold OUT_READY=0 for 3 DONE cycles while IN_VALID=1 -> outputs stable, IN_READY=0, no second acceptance; OUT_READY=1 -> IDLE on the next cycle.
REQ-042 Reset mid-op: assert RST at RUN byte 2 -> next cycle IDLE, OUT_VALID=0, Y=0, ADD_A=ADD_B=0; a new op then completes correctly.
